// File: rtl/pipe_pkg.sv
// pipe_pkg
//   Shared definitions for the pipe_stage_chain block:
//     - legal bounds for the STAGES parameter
//     - default payload width
//     - stage_ctrl_e: per-stage register control encoding
//       (LOAD from the previous stage, HOLD current contents,
//        BUBBLE = load an empty slot, KILL = squash to empty)
package pipe_pkg;

  localparam int STAGES_MIN     = 2;
  localparam int STAGES_MAX     = 8;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    CTRL_LOAD   = 2'd0,
    CTRL_HOLD   = 2'd1,
    CTRL_BUBBLE = 2'd2,
    CTRL_KILL   = 2'd3
  } stage_ctrl_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   One pipeline slot: a valid bit plus a DATA_W payload, updated each
//   rising edge according to a stage_ctrl_e command.
//
// Ports
//   clk          rising-edge clock
//   clr          synchronous active-high clear (valid and payload to 0)
//   ctrl_i       LOAD / HOLD / BUBBLE / KILL for this slot
//   prev_valid_i valid bit offered by the younger neighbour (or input)
//   prev_data_i  payload offered by the younger neighbour (or input)
//   valid_o      registered valid bit
//   data_o       registered payload
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clr,
  input  stage_ctrl_e       ctrl_i,
  input  logic              prev_valid_i,
  input  logic [DATA_W-1:0] prev_data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
    case (ctrl_i)
      CTRL_LOAD: begin
        valid_d = prev_valid_i;
        data_d  = prev_data_i;
      end
      CTRL_HOLD: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      // Bubbles and kills both leave an empty slot with a zero payload.
      CTRL_BUBBLE, CTRL_KILL: begin
        valid_d = 1'b0;
        data_d  = '0;
      end
      default: begin
        valid_d = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  // payload is cleared by clr as well, so a cleared chain never exposes stale data
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Linear chain of STAGES valid+payload registers with per-stage stall
//   and flush. Stage 0 is the youngest, stage STAGES-1 the oldest.
//   A stall on stage k holds k and every younger stage; a flush on
//   stage k squashes k and every younger stage. Flush wins over stall
//   on any stage it covers, so a stall bit inside a flushed region is
//   ignored (no hold, no bubble) while a stall on an older, unflushed
//   stage still holds those older stages.
//
// Optional feature (macro PIPE_PERF_CNT_EN):
//   adds saturating counters bubble_cnt (cycles with a bubble inserted)
//   and kill_cnt (valid stages squashed). Absent when undefined.
//
// Ports
//   clk          rising-edge clock
//   clr          synchronous active-high clear of stages and counters
//   in_valid     payload offered to stage 0
//   in_data      payload
//   in_ready     stage 0 accepts this cycle (not held)
//   stall        bit k holds stage k and younger
//   flush        bit k kills stage k and younger
//   stage_valid  registered valid bit per stage
//   stage_data   registered payloads, stage k at [k*DATA_W +: DATA_W]
//   out_valid    oldest stage retires this cycle
//   out_data     oldest stage payload
//   bubble_cnt   (PIPE_PERF_CNT_EN) bubble-insertion cycle count
//   kill_cnt     (PIPE_PERF_CNT_EN) killed valid stage count
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int STAGES = 4,
  parameter int CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic                     out_valid,
`ifdef PIPE_PERF_CNT_EN
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         kill_cnt,
`endif
  output logic [DATA_W-1:0]        out_data
);

  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  stage_ctrl_e       ctrl   [STAGES];
  logic              v_p    [STAGES];
  logic [DATA_W-1:0] d_p    [STAGES];

  // Suffix-OR from the oldest stage down. A stall bit only contributes
  // when its stage is not killed, so flush dominates stall.
  always_comb begin
    logic acc_k;
    logic acc_h;
    acc_k = 1'b0;
    acc_h = 1'b0;
    kill  = '0;
    hold  = '0;
    for (int j = STAGES - 1; j >= 0; j--) begin
      acc_k   = acc_k | flush[j];
      kill[j] = acc_k;
      acc_h   = acc_h | (stall[j] & ~acc_k);
      hold[j] = acc_h;
    end
  end

  // ---- stage registers ----
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic              prev_v;
    logic [DATA_W-1:0] prev_d;

    if (g == 0) begin : g_first
      assign prev_v  = in_valid;
      assign prev_d  = in_data;
      assign ctrl[g] = kill[g] ? CTRL_KILL :
                       hold[g] ? CTRL_HOLD : CTRL_LOAD;
    end else begin : g_rest
      assign prev_v  = v_p[g-1];
      assign prev_d  = d_p[g-1];
      // held younger neighbour + free-running self => insert a bubble
      assign ctrl[g] = kill[g]   ? CTRL_KILL   :
                       hold[g]   ? CTRL_HOLD   :
                       hold[g-1] ? CTRL_BUBBLE : CTRL_LOAD;
    end

    pipe_stage_reg #(
      .DATA_W(DATA_W)
    ) u_reg (
      .clk         (clk),
      .clr         (clr),
      .ctrl_i      (ctrl[g]),
      .prev_valid_i(prev_v),
      .prev_data_i (prev_d),
      .valid_o     (v_p[g]),
      .data_o      (d_p[g])
    );

    assign stage_valid[g]                   = v_p[g];
    assign stage_data[g*DATA_W +: DATA_W]   = d_p[g];
  end

  // ---- chain boundaries ----
  assign in_ready  = ~hold[0];
  assign out_valid = v_p[STAGES-1] & ~hold[STAGES-1];
  assign out_data  = d_p[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
  localparam int KC_W = $clog2(STAGES + 1);

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] kill_cnt_q, kill_cnt_d;
  logic             bubble_any;
  logic [KC_W-1:0]  kill_num;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    bubble_any = 1'b0;
    kill_num   = '0;
    for (int j = 0; j < STAGES; j++) begin
      bubble_any = bubble_any | (ctrl[j] == CTRL_BUBBLE);
      kill_num   = kill_num + KC_W'(kill[j] & v_p[j]);
    end
    bubble_cnt_d = sat_add(bubble_cnt_q, CNT_W'(bubble_any));
    kill_cnt_d   = sat_add(kill_cnt_q, CNT_W'(kill_num));
  end

  // ---- performance counters ----
  always_ff @(posedge clk) begin
    if (clr) begin
      bubble_cnt_q <= '0;
      kill_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      kill_cnt_q   <= kill_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign kill_cnt   = kill_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

  localparam int DW = 8;
  localparam int ST = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic [ST-1:0]    stall;
  logic [ST-1:0]    flush;
  logic [ST-1:0]    stage_valid;
  logic [ST*DW-1:0] stage_data;
  logic             out_valid;
  logic [DW-1:0]    out_data;
`ifdef PIPE_PERF_CNT_EN
  logic [CW-1:0]    bubble_cnt;
  logic [CW-1:0]    kill_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(
    .DATA_W(DW),
    .STAGES(ST),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .stage_valid(stage_valid),
    .stage_data (stage_data),
    .out_valid  (out_valid),
`ifdef PIPE_PERF_CNT_EN
    .bubble_cnt (bubble_cnt),
    .kill_cnt   (kill_cnt),
`endif
    .out_data   (out_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    in_data  = '0;
    stall    = '0;
    flush    = '0;
    for (int i = 0; i < ST + 1; i++) tick();
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h55; stall = '0; flush = '0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    tick(); tick();
    n_checks++;
    if (stage_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", stage_valid); end
    n_checks++;
    if (stage_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", stage_data); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (bubble_cnt !== 4'h0 || kill_cnt !== 4'h0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h want 0/0", bubble_cnt, kill_cnt);
    end
`endif
    clr = 1'b0; in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_stream();
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      in_data  = (c < 4) ? DW'(8'h11 + c) : '0;
      #1;
      n_checks++;
      if (out_valid !== ((c >= 4) && (c <= 7))) begin
        n_fail++; $display("FAIL stream_valid c=%0d: got %b want %b", c, out_valid, (c >= 4) && (c <= 7));
      end
      if (c >= 4 && c <= 7) begin
        n_checks++;
        if (out_data !== DW'(8'h11 + c - 4)) begin
          n_fail++; $display("FAIL stream_data c=%0d: got %h want %h", c, out_data, 8'h11 + c - 4);
        end
      end
      tick();
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic test_load_use();
    drain();
    push(8'hA0);
    stall = 4'b0001; in_valid = 1'b1; in_data = 8'hB0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL loaduse_in_ready: got %b want 0", in_ready); end
    tick();
    stall = '0; in_valid = 1'b0; in_data = '0;
    n_checks++;
    if (stage_valid !== 4'b0001 || stage_data[7:0] !== 8'hA0) begin
      n_fail++; $display("FAIL loaduse_bubble: got %b/%h want 0001/a0", stage_valid, stage_data[7:0]);
    end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (bubble_cnt !== 4'h1) begin n_fail++; $display("FAIL loaduse_bubble_cnt: got %h want 1", bubble_cnt); end
`endif
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL loaduse_not_early: got %b want 0", out_valid); end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      n_fail++; $display("FAIL loaduse_exit: got %b/%h want 1/a0", out_valid, out_data);
    end
  endtask

  task automatic test_kill();
    drain();
    push(8'hC1); push(8'hC2); push(8'hC3);
    n_checks++;
    if (stage_valid !== 4'b0111) begin n_fail++; $display("FAIL kill_pre: got %b want 0111", stage_valid); end
    flush = 4'b0100;
    tick();
    flush = '0;
    n_checks++;
    if (stage_valid !== 4'b1000 || out_valid !== 1'b1 || out_data !== 8'hC1) begin
      n_fail++; $display("FAIL kill_result: got %b/%b/%h want 1000/1/c1", stage_valid, out_valid, out_data);
    end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (kill_cnt !== 4'h3) begin n_fail++; $display("FAIL kill_cnt: got %h want 3", kill_cnt); end
`endif
  endtask

  task automatic test_conflict();
    drain();
    push(8'hD1); push(8'hD2);
    stall = 4'b0010; flush = 4'b0010;
    tick();
    stall = '0; flush = '0;
    n_checks++;
    if (stage_valid !== 4'b0100 || stage_data[23:16] !== 8'hD1) begin
      n_fail++; $display("FAIL conflict_stages: got %b/%h want 0100/d1", stage_valid, stage_data[23:16]);
    end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (bubble_cnt !== 4'h1 || kill_cnt !== 4'h5) begin
      n_fail++; $display("FAIL conflict_counters: got %h/%h want 1/5", bubble_cnt, kill_cnt);
    end
`endif
  endtask

  task automatic test_hold_older();
    drain();
    push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
    stall = 4'b1000; flush = 4'b0010;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_older_comb: got %b/%b want 0/0", out_valid, in_ready);
    end
    tick();
    stall = '0; flush = '0;
    n_checks++;
    if (stage_valid !== 4'b1100 || stage_data[31:16] !== 16'hE1E2) begin
      n_fail++; $display("FAIL hold_older_stages: got %b/%h want 1100/e1e2", stage_valid, stage_data[31:16]);
    end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (kill_cnt !== 4'h7) begin n_fail++; $display("FAIL hold_older_kill_cnt: got %h want 7", kill_cnt); end
`endif
  endtask

  task automatic test_clr_midstream();
    push(8'hF1); push(8'hF2); push(8'hF3); push(8'hF4);
    n_checks++;
    if (stage_valid !== 4'b1111) begin n_fail++; $display("FAIL clr_pre: got %b want 1111", stage_valid); end
    stall = 4'b1111; clr = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    clr = 1'b0; stall = '0; in_valid = 1'b0; in_data = '0;
    n_checks++;
    if (stage_valid !== 4'b0000 || stage_data !== 32'h0) begin
      n_fail++; $display("FAIL clr_stages: got %b/%h want 0000/0", stage_valid, stage_data);
    end
`ifdef PIPE_PERF_CNT_EN
    n_checks++;
    if (bubble_cnt !== 4'h0 || kill_cnt !== 4'h0) begin
      n_fail++; $display("FAIL clr_counters: got %h/%h want 0/0", bubble_cnt, kill_cnt);
    end
`endif
  endtask

  task automatic test_saturation();
    stall = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      tick();
`ifdef PIPE_PERF_CNT_EN
      if (i == 14 || i == 15 || i == 20) begin
        n_checks++;
        if (bubble_cnt !== ((i == 14) ? 4'hE : 4'hF)) begin
          n_fail++; $display("FAIL sat_bubble i=%0d: got %h want %h", i, bubble_cnt, (i == 14) ? 4'hE : 4'hF);
        end
      end
`endif
    end
    stall = '0;
    n_checks++;
    if (stage_valid !== 4'b0000) begin n_fail++; $display("FAIL sat_empty: got %b want 0000", stage_valid); end
  endtask

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    test_reset();
    test_stream();
    test_load_use();
    test_kill();
    test_conflict();
    test_hold_older();
    test_clr_midstream();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width per stage.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline registers (legal 2..8).
REQ-003 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-004 SHALL have one clock and a synchronous active-high reset: port clk (input, 1), rising-edge clock for all state.
REQ-005 SHALL have port clr (input, 1), synchronous active-high reset.
REQ-006 SHALL have port in_valid (input, 1), payload offered to stage 0.
REQ-007 SHALL have port in_data (input, DATA_W), payload.
REQ-008 SHALL have port in_ready (output, 1), stage 0 accepts this cycle.
REQ-009 SHALL have port stall (input, STAGES), bit k requests hold of stage k and all younger stages.
REQ-010 SHALL have port flush (input, STAGES), bit k kills stage k and all younger stages.
REQ-011 SHALL have port stage_valid (output, STAGES), registered valid bit per stage.
REQ-012 SHALL have port stage_data (output, STAGES*DATA_W), registered payloads, stage k at [k*DATA_W +: DATA_W].
REQ-013 SHALL have port out_valid (output, 1), oldest stage retires this cycle.
REQ-014 SHALL have port out_data (output, DATA_W), oldest stage payload.

Function
REQ-015 Stage 0 is youngest and stage STAGES-1 oldest; data moves k to k+1 each unheld cycle.
REQ-016 hold[j] SHALL equal OR of stall[k] for k>=j; kill[j] SHALL equal OR of flush[k] for k>=j.
REQ-017 in_ready SHALL equal !hold[0], combinationally.
REQ-018 Unheld, unkilled stage 0 SHALL load in_valid/in_data at the next edge; in_valid=0 loads valid 0.
REQ-019 Stage j>0 unheld and unkilled SHALL load stage j-1 valid and data at the next edge.
REQ-020 Stage j held and unkilled SHALL retain valid and data.
REQ-021 Stage j+1 with hold[j]=1 and hold[j+1]=0 SHALL receive a bubble: valid 0, data all zero.
REQ-022 Killed stage SHALL load valid 0, data zero, overriding hold and stall.
REQ-023 out_valid SHALL equal stage_valid[STAGES-1] AND !hold[STAGES-1]; out_data SHALL equal stage_data[STAGES-1].
REQ-024 Latency SHALL be STAGES cycles from accepted input to out_valid when no stall or flush is asserted.
REQ-025 Flush and stall asserted on the same stage SHALL behave as flush.
REQ-026 A stall on a stage older than a flush SHALL still hold the stages older than the flush point only when those stages are not killed.

Reset
REQ-027 clr=1 SHALL clear all stage valid bits, payloads, and counters at the next edge, overriding stall and flush.
REQ-028 in_ready SHALL be 1 while clr=1 and no stall is asserted; inputs presented during clr SHALL be discarded.

Configuration
REQ-029 Macro PIPE_PERF_CNT_EN defined SHALL add outputs bubble_cnt and kill_cnt (each CNT_W).
REQ-030 With PIPE_PERF_CNT_EN defined, bubble_cnt SHALL add 1 per cycle in which a REQ-021 bubble is inserted.
REQ-031 With PIPE_PERF_CNT_EN defined, kill_cnt SHALL add the number of valid stages killed that cycle.
REQ-032 With PIPE_PERF_CNT_EN defined, both counters SHALL saturate at all-ones.
REQ-033 Without PIPE_PERF_CNT_EN, the counter ports and counter logic SHALL be absent.

Structure
REQ-034 Package pipe_pkg SHALL hold the STAGES legal bounds, the default DATA_W, and the stage-control encoding typedef (LOAD, HOLD, BUBBLE, KILL).
REQ-035 One sub-module, pipe_stage_reg, SHALL implement a single valid+payload register driven by that encoding, instantiated STAGES times.

Verification
REQ-036 Stream: STAGES=4, inputs 0x11..0x14 on consecutive cycles -> out_valid pulses on cycles 4..7 with 0x11..0x14.
REQ-037 Load-use stall: stall=4'b0001 for 1 cycle with 0xA0 in stage 0 -> stage 1 bubble, in_ready=0, 0xA0 exits one cycle late, bubble_cnt=1.
REQ-038 Branch kill: three valid stages, flush=4'b0100 -> stages 0..2 valid 0 next cycle, stage 3 retires, kill_cnt=3.
REQ-039 Same-stage conflict: stall=4'b0010 and flush=4'b0010 together -> stages 0..1 killed, no bubble counted.
REQ-040 Reset mid-stream: clr pulsed with all stages valid and stall=4'b1111 -> all stage_valid 0 and counters 0 next cycle.
REQ-041 Saturation: CNT_W=4, 20 bubble cycles -> bubble_cnt=4'hF held.
